serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e   : controller state encoding (Idle, Shift, Done)
//   WidthMin  : smallest supported operand width
//   WidthMax  : largest supported operand width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned WidthMin = 2;
    localparam int unsigned WidthMax = 32;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit combinational full subtractor: computes x - y - bin.
// Ports:
//   x_i    : minuend bit
//   y_i    : subtrahend bit
//   bin_i  : borrow in
//   d_o    : difference bit
//   bout_o : borrow out
module full_subtractor (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = x_i ^ y_i ^ bin_i;
    assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// A start pulse in Idle latches the operands; Shift runs WIDTH cycles through one
// full_subtractor cell; Done pulses for a single cycle, after which the results hold
// until the next accepted start.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf_o.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start_i : request an operation (sampled only in Idle)
//   a_i     : minuend, captured on accepted start
//   b_i     : subtrahend, captured on accepted start
//   busy_o  : high while bits are being processed
//   done_o  : one-cycle pulse, results valid from this cycle on
//   diff_o  : a - b modulo 2^WIDTH
//   bout_o  : final borrow (a < b unsigned)
//   ovf_o   : signed overflow of a - b (SERIAL_SUB_OVF_EN only)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    if ((WIDTH < WidthMin) || (WIDTH > WidthMax)) begin : g_width_check
        $error("serial_subtractor: WIDTH out of range");
    end

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic             borrow_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;

    logic             fs_d;
    logic             fs_bout;

    full_subtractor u_full_subtractor (
        .x_i    (a_sr_q[0]),
        .y_i    (b_sr_q[0]),
        .bin_i  (borrow_q),
        .d_o    (fs_d),
        .bout_o (fs_bout)
    );

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept separately because the shift registers lose them.
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (state_q == StIdle && start_i) begin
                a_msb_q <= a_i[WIDTH-1];
                b_msb_q <= b_i[WIDTH-1];
            end
            // On the last bit fs_d is the result sign bit.
            if (state_q == StShift && cnt_q == CntLast) begin
                ovf_q <= (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
            end
        end
    end

    assign ovf_o = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_sr_q   <= a_i;
                        b_sr_q   <= b_i;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    borrow_q <= fs_bout;
                    diff_q   <= {fs_d, diff_q[WIDTH-1:1]};
                    if (cnt_q == CntLast) begin
                        // Counter holds here so it never wraps inside an operation.
                        bout_q  <= fs_bout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bout_o = bout_q;

endmodule
